// File: rtl/btb_assoc.sv
// Set-associative branch target buffer with per-entry confidence counters,
// round-robin replacement on full sets and a one-set-per-cycle flush sequencer.
module btb_assoc #(
   parameter int ADDR   = 32,
   parameter int BTB_D  = 32,
   parameter int WAYS   = 2,
   parameter int CNT    = 2,
   parameter int OFFSET = 2
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [ADDR-1:0] pc,
   output logic            btb_hit,
   output logic [ADDR-1:0] btb_addr,
   input  logic            br_commit_,
   input  logic            br_taken_,
   input  logic            br_miss_,
   input  logic            jump_commit_,
   input  logic            jump_miss_,
   input  logic [ADDR-1:0] com_addr,
   input  logic [ADDR-1:0] com_tar_addr,
   input  logic            flush_,
   output logic            btb_busy
);
   localparam int IDX  = $clog2(BTB_D);
   localparam int TAGW = ADDR - OFFSET - IDX;
   localparam int WW   = (WAYS > 1) ? $clog2(WAYS) : 1;
   localparam logic [CNT-1:0] THR  = CNT'(1 << (CNT - 1));
   localparam logic [CNT-1:0] CMAX = '1;

   typedef enum logic {IDLE, FLUSH} state_t;

   state_t            state_q, state_d;
   logic [IDX-1:0]    ptr_q, ptr_d;
   logic [WAYS-1:0]   valid_q [BTB_D];
   logic [WAYS-1:0]   valid_d [BTB_D];
   logic [CNT-1:0]    cnt_q   [BTB_D][WAYS];
   logic [CNT-1:0]    cnt_d   [BTB_D][WAYS];
   logic [WW-1:0]     rr_q    [BTB_D];
   logic [WW-1:0]     rr_d    [BTB_D];
   logic [TAGW-1:0]   tag_q   [BTB_D][WAYS];
   logic [TAGW-1:0]   tag_d   [BTB_D][WAYS];
   logic [ADDR-1:0]   tgt_q   [BTB_D][WAYS];
   logic [ADDR-1:0]   tgt_d   [BTB_D][WAYS];
   logic [WAYS-1:0]   jmp_q   [BTB_D];
   logic [WAYS-1:0]   jmp_d   [BTB_D];
   logic              hit_q, hit_d;
   logic [ADDR-1:0]   addr_q, addr_d;

   logic [IDX-1:0]    lk_set, c_set;
   logic [TAGW-1:0]   lk_tag, c_tag;
   logic              c_hit, c_inv;
   logic [WW-1:0]     c_hw, c_iw, c_way;

   // jump_miss_ carries no state beyond the target write a jump commit already does
   logic              unused_jump_miss;
   assign unused_jump_miss = jump_miss_;

   assign btb_hit  = hit_q;
   assign btb_addr = addr_q;
   assign btb_busy = (state_q == FLUSH);

   // Lookup against pre-update contents; suppressed while flushing
   always_comb begin
      lk_set = pc[OFFSET +: IDX];
      lk_tag = pc[ADDR-1 -: TAGW];
      hit_d  = 1'b0;
      addr_d = '0;
      for (int unsigned w = 0; w < WAYS; w++) begin
         if (valid_q[lk_set][w] && tag_q[lk_set][w] == lk_tag &&
             (jmp_q[lk_set][w] || cnt_q[lk_set][w] >= THR)) begin
            hit_d  = 1'b1;
            addr_d = tgt_q[lk_set][w];
         end
      end
      if (state_q == FLUSH || !flush_) begin
         hit_d  = 1'b0;
         addr_d = '0;
      end
   end

   // Commit-side way selection: hit way, else lowest invalid way, else round-robin
   always_comb begin
      c_set = com_addr[OFFSET +: IDX];
      c_tag = com_addr[ADDR-1 -: TAGW];
      c_hit = 1'b0;
      c_hw  = '0;
      c_inv = 1'b0;
      c_iw  = '0;
      for (int unsigned w = 0; w < WAYS; w++) begin
         if (valid_q[c_set][w] && tag_q[c_set][w] == c_tag) begin
            c_hit = 1'b1;
            c_hw  = WW'(w);
         end
         if (!c_inv && !valid_q[c_set][w]) begin
            c_inv = 1'b1;
            c_iw  = WW'(w);
         end
      end
      c_way = c_hit ? c_hw : (c_inv ? c_iw : rr_q[c_set]);
   end

   // Training, allocation and flush sequencing
   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      valid_d = valid_q;
      cnt_d   = cnt_q;
      rr_d    = rr_q;
      tag_d   = tag_q;
      tgt_d   = tgt_q;
      jmp_d   = jmp_q;
      if (state_q == IDLE) begin
         if (!jump_commit_) begin
            valid_d[c_set][c_way] = 1'b1;
            tag_d[c_set][c_way]   = c_tag;
            tgt_d[c_set][c_way]   = com_tar_addr;
            jmp_d[c_set][c_way]   = 1'b1;
            cnt_d[c_set][c_way]   = CMAX;
            if (!c_hit && !c_inv && WAYS > 1) rr_d[c_set] = rr_q[c_set] + 1'b1;
         end else if (!br_commit_ && !br_taken_) begin
            tgt_d[c_set][c_way] = com_tar_addr;
            jmp_d[c_set][c_way] = 1'b0;
            if (c_hit) begin
               if (cnt_q[c_set][c_way] != CMAX) cnt_d[c_set][c_way] = cnt_q[c_set][c_way] + 1'b1;
            end else begin
               valid_d[c_set][c_way] = 1'b1;
               tag_d[c_set][c_way]   = c_tag;
               cnt_d[c_set][c_way]   = THR;
               if (!c_inv && WAYS > 1) rr_d[c_set] = rr_q[c_set] + 1'b1;
            end
         end else if (!br_commit_ && c_hit) begin
            if (!br_miss_) valid_d[c_set][c_way] = 1'b0;
            else if (cnt_q[c_set][c_way] != '0) cnt_d[c_set][c_way] = cnt_q[c_set][c_way] - 1'b1;
         end
         if (!flush_) begin
            state_d = FLUSH;
            ptr_d   = '0;
         end
      end else begin
         valid_d[ptr_q] = '0;
         for (int unsigned w = 0; w < WAYS; w++) cnt_d[ptr_q][w] = '0;
         if (!flush_) ptr_d = '0;
         else if (ptr_q == IDX'(BTB_D - 1)) state_d = IDLE;
         else ptr_d = ptr_q + 1'b1;
      end
   end

   // Control state, valid bits, counters and lookup outputs
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         ptr_q   <= '0;
         hit_q   <= 1'b0;
         addr_q  <= '0;
         for (int unsigned s = 0; s < BTB_D; s++) begin
            valid_q[s] <= '0;
            rr_q[s]    <= '0;
            for (int unsigned w = 0; w < WAYS; w++) cnt_q[s][w] <= '0;
         end
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         hit_q   <= hit_d;
         addr_q  <= addr_d;
         valid_q <= valid_d;
         rr_q    <= rr_d;
         cnt_q   <= cnt_d;
      end
   end

   // Tag, target and type arrays need no reset; valid gates them
   always_ff @(posedge clk) begin
      tag_q <= tag_d;
      tgt_q <= tgt_d;
      jmp_q <= jmp_d;
   end
endmodule

// File: tb/tb_btb_assoc.sv
// Directed bench for btb_assoc: lookup latency, branch/jump training,
// replacement in a conflicting set, flush length and reset during flush.
module tb_btb_assoc;
   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [31:0] pc = 32'hdeadbe74;
   logic        btb_hit;
   logic [31:0] btb_addr;
   logic        br_commit_ = 1'b1, br_taken_ = 1'b1, br_miss_ = 1'b1;
   logic        jump_commit_ = 1'b1, jump_miss_ = 1'b1;
   logic [31:0] com_addr = '0, com_tar_addr = '0;
   logic        flush_ = 1'b1;
   logic        btb_busy;
   int          n_chk = 0, n_pass = 0;

   btb_assoc #(.ADDR(32), .BTB_D(32), .WAYS(2), .CNT(2), .OFFSET(2)) dut (
      .clk(clk), .reset(reset), .pc(pc), .btb_hit(btb_hit), .btb_addr(btb_addr),
      .br_commit_(br_commit_), .br_taken_(br_taken_), .br_miss_(br_miss_),
      .jump_commit_(jump_commit_), .jump_miss_(jump_miss_),
      .com_addr(com_addr), .com_tar_addr(com_tar_addr),
      .flush_(flush_), .btb_busy(btb_busy));

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic lookup(input string tag, input logic [31:0] a, input logic h, input logic [31:0] t);
      pc = a;
      tick();
      check({tag, "_hit"}, {31'd0, btb_hit}, {31'd0, h});
      check({tag, "_addr"}, btb_addr, t);
   endtask

   task automatic jump(input logic [31:0] a, input logic [31:0] t);
      jump_commit_ = 1'b0; com_addr = a; com_tar_addr = t;
      tick();
      jump_commit_ = 1'b1;
   endtask

   task automatic branch(input logic [31:0] a, input logic [31:0] t, input logic taken, input logic miss);
      br_commit_ = 1'b0; br_taken_ = ~taken; br_miss_ = ~miss;
      com_addr = a; com_tar_addr = t;
      tick();
      br_commit_ = 1'b1; br_taken_ = 1'b1; br_miss_ = 1'b1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      tick();
      reset = 1'b0;
   endtask

   initial begin
      int n;
      // reset state
      #2;
      check("rst_hit", {31'd0, btb_hit}, 32'd0);
      check("rst_addr", btb_addr, 32'd0);
      check("rst_busy", {31'd0, btb_busy}, 32'd0);
      tick();
      reset = 1'b0;
      for (int i = 0; i < 3; i++) lookup("idle", 32'hdeadbe74, 1'b0, 32'd0);

      // jump training and lookup
      jump(32'hdeadbe74, 32'hcafecafc);
      lookup("jmp_hit", 32'hdeadbe74, 1'b1, 32'hcafecafc);
      lookup("jmp_nb", 32'hdeadbe78, 1'b0, 32'd0);

      // conditional branch confidence
      branch(32'h74, 32'h100, 1'b1, 1'b0);
      lookup("br_alloc", 32'h74, 1'b1, 32'h100);
      branch(32'h74, 32'h100, 1'b0, 1'b1);
      lookup("br_inval", 32'h74, 1'b0, 32'd0);
      branch(32'h74, 32'h100, 1'b1, 1'b0);
      branch(32'h74, 32'h100, 1'b1, 1'b0);
      lookup("br_cnt3", 32'h74, 1'b1, 32'h100);
      branch(32'h74, 32'h100, 1'b0, 1'b0);
      lookup("br_cnt2", 32'h74, 1'b1, 32'h100);
      branch(32'h74, 32'h100, 1'b0, 1'b0);
      lookup("br_cnt1", 32'h74, 1'b0, 32'd0);
      lookup("jmp_keep", 32'hdeadbe74, 1'b1, 32'hcafecafc);

      // replacement in set 29
      do_reset();
      jump(32'h74, 32'ha0);
      jump(32'h1074, 32'hb0);
      lookup("cf_w0", 32'h74, 1'b1, 32'ha0);
      lookup("cf_w1", 32'h1074, 1'b1, 32'hb0);
      jump(32'h2074, 32'hc0);
      lookup("cf_ev0", 32'h74, 1'b0, 32'd0);
      lookup("cf_keep1", 32'h1074, 1'b1, 32'hb0);
      lookup("cf_new0", 32'h2074, 1'b1, 32'hc0);
      jump(32'h3074, 32'hd0);
      lookup("cf_ev1", 32'h1074, 1'b0, 32'd0);
      lookup("cf_keep0", 32'h2074, 1'b1, 32'hc0);
      lookup("cf_new1", 32'h3074, 1'b1, 32'hd0);

      // full flush
      jump(32'h10, 32'h1000);
      jump(32'h20, 32'h2000);
      jump(32'h40, 32'h4000);
      jump(32'h7c, 32'h7000);
      lookup("pre_fl", 32'h7c, 1'b1, 32'h7000);
      flush_ = 1'b0;
      tick();
      flush_ = 1'b1;
      n = 0;
      while (btb_busy && n < 100) begin
         if (n == 3) check("fl_hit", {31'd0, btb_hit}, 32'd0);
         if (n == 5) begin
            jump_commit_ = 1'b0; com_addr = 32'h300; com_tar_addr = 32'h999;
         end
         if (n == 6) jump_commit_ = 1'b1;
         n++;
         tick();
      end
      check("fl_len", n, 32'd32);
      lookup("fl_a", 32'h10, 1'b0, 32'd0);
      lookup("fl_b", 32'h20, 1'b0, 32'd0);
      lookup("fl_c", 32'h40, 1'b0, 32'd0);
      lookup("fl_d", 32'h7c, 1'b0, 32'd0);
      lookup("fl_ign", 32'h300, 1'b0, 32'd0);
      lookup("fl_e", 32'h2074, 1'b0, 32'd0);
      jump(32'h10, 32'h1111);
      lookup("post_fl", 32'h10, 1'b1, 32'h1111);

      // reset in the middle of a flush
      jump(32'h7c, 32'h7777);
      flush_ = 1'b0;
      tick();
      flush_ = 1'b1;
      for (int i = 0; i < 10; i++) tick();
      check("mid_busy1", {31'd0, btb_busy}, 32'd1);
      reset = 1'b1;
      #1;
      check("mid_busy0", {31'd0, btb_busy}, 32'd0);
      tick();
      reset = 1'b0;
      lookup("mid_a", 32'h10, 1'b0, 32'd0);
      lookup("mid_d", 32'h7c, 1'b0, 32'd0);
      check("mid_idle", {31'd0, btb_busy}, 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
